dmem_lsu: RTL and testbench

//   Parametrised successor of the single-port data memory. Supports byte, half
//   and word loads/stores with byte-lane write enables and load sign/zero

---
 rtl/types_pkg.sv | 25 ++
 rtl/dmem_lane_align.sv | 87 ++++++++
 rtl/dmem_lsu.sv | 139 +++++++++++++
 tb/tb_dmem_lsu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared core types: word/address types, memory-size and LSU state enums.
// Used by the data-memory LSU and its lane aligner.
package types_pkg;

  localparam int XLEN           = 32;
  localparam int ADDR_WIDTH     = 32;
  localparam int MEM_SIZE       = 1024;
  localparam int BYTES_PER_WORD = XLEN / 8;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [ADDR_WIDTH-1:0] address_t;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for dmem_lsu: store enables/data, load extract/extend.
// `DMEM_MISALIGN_TRAP_EN enables misalignment detection.
module dmem_lane_align
  import types_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFFW       = $clog2(DATA_WIDTH / 8)
) (
  input  mem_size_e               st_size,
  input  logic [OFFW-1:0]         st_off,
  input  logic [DATA_WIDTH-1:0]   st_wdata,
  output logic [DATA_WIDTH/8-1:0] st_be,
  output logic [DATA_WIDTH-1:0]   st_data,
  output logic                    st_mis,
  input  mem_size_e               ld_size,
  input  logic [OFFW-1:0]         ld_off,
  input  logic                    ld_unsigned,
  input  logic [DATA_WIDTH-1:0]   ld_word,
  output logic [DATA_WIDTH-1:0]   ld_data
);

  localparam int BPW = DATA_WIDTH / 8;

  function automatic logic [OFFW-1:0] align_off(
    input mem_size_e s,
    input logic [OFFW-1:0] o
  );
    unique case (1'b1)
      s == BYTE: return o;
      s == HALF: return {o[OFFW-1:1], 1'b0};
      default:   return '0;
    endcase
  endfunction

  function automatic logic is_mis(
    input mem_size_e s,
    input logic [OFFW-1:0] o
  );
    return (s == HALF && o[0]) ||
           (s != BYTE && s != HALF && o != '0);
  endfunction

  logic [OFFW-1:0] so;
  logic [OFFW-1:0] lo;
  logic [15:0]     sh;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign st_mis = is_mis(st_size, st_off);
`else
  assign st_mis = 1'b0;
`endif

  always_comb begin
    so      = align_off(st_size, st_off);
    st_be   = '0;
    st_data = '0;
    unique case (1'b1)
      st_size == BYTE: begin
        st_be   = BPW'(1) << so;
        st_data = {BPW{st_wdata[7:0]}};
      end
      st_size == HALF: begin
        st_be   = BPW'(3) << so;
        st_data = {(BPW/2){st_wdata[15:0]}};
      end
      default: begin
        st_be   = '1;
        st_data = st_wdata;
      end
    endcase
  end

  always_comb begin
    lo      = align_off(ld_size, ld_off);
    sh      = 16'(ld_word >> {lo, 3'b000});
    ld_data = ld_word;
    unique case (1'b1)
      ld_size == BYTE:
        ld_data = {{(DATA_WIDTH-8){sh[7] & ~ld_unsigned}}, sh[7:0]};
      ld_size == HALF:
        ld_data = {{(DATA_WIDTH-16){sh[15] & ~ld_unsigned}}, sh};
      default:
        ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit with valid/ready request and fixed latency.
// `DMEM_MISALIGN_TRAP_EN turns misaligned accesses into resp_err.
module dmem_lsu
  import types_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = MEM_SIZE,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  mem_size_e             req_size,
  input  logic                  req_unsigned,
  input  address_t              req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int BPW  = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(BPW);
  localparam int IDXW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [2:0] CNT_LOAD =
    LATENCY > 1 ? 3'(LATENCY - 2) : 3'd0;

  typedef struct packed {
    logic            we;
    mem_size_e       size;
    logic            uns;
    logic [OFFW-1:0] off;
    logic            mis;
  } req_t;

  dmem_state_e state, state_n;
  logic [2:0]  cnt, cnt_n;
  req_t        rq;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;

  logic                  accept;
  logic [IDXW-1:0]       idx;
  logic [BPW-1:0]        st_be;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  st_mis;
  logic [DATA_WIDTH-1:0] ld_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready & ~rst;
  assign idx       = IDXW'((req_addr >> OFFW) % DEPTH);

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFFW       (OFFW)
  ) u_align (
    .st_size     (req_size),
    .st_off      (req_addr[OFFW-1:0]),
    .st_wdata    (req_wdata),
    .st_be       (st_be),
    .st_data     (st_data),
    .st_mis      (st_mis),
    .ld_size     (rq.size),
    .ld_off      (rq.off),
    .ld_unsigned (rq.uns),
    .ld_word     (rd_q),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_n = RESP;
        else           cnt_n   = cnt - 3'd1;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rq    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        rq.we   <= req_we;
        rq.size <= req_size;
        rq.uns  <= req_unsigned;
        rq.off  <= req_addr[OFFW-1:0];
        rq.mis  <= st_mis;
      end
    end
  end

  // Read-before-write on the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q <= mem[idx];
      if (req_we && !st_mis) begin
        for (int b = 0; b < BPW; b++) begin
          if (st_be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  assign resp_rdata =
    (resp_valid && !rq.we && !rq.mis) ? ld_data : '0;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign resp_err = resp_valid & rq.mis;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: LATENCY=1 and LATENCY=3 instances.
// Byte-array reference model plus directed literal expectations.
module tb_dmem_lsu;
  import types_pkg::*;

  localparam int DEPTH = 16;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic      rst  [2];
  logic      rv   [2];
  logic      rdy  [2];
  logic      we   [2];
  mem_size_e sz   [2];
  logic      un   [2];
  address_t  ad   [2];
  word_t     wd   [2];
  logic      vld  [2];
  word_t     rdat [2];
  logic      er   [2];

  int checks   = 0;
  int failures = 0;

  dmem_lsu #(.DATA_WIDTH(32), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_we(we[0]), .req_size(sz[0]), .req_unsigned(un[0]),
    .req_addr(ad[0]), .req_wdata(wd[0]), .resp_valid(vld[0]),
    .resp_rdata(rdat[0]), .resp_err(er[0])
  );

  dmem_lsu #(.DATA_WIDTH(32), .DEPTH(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_we(we[1]), .req_size(sz[1]), .req_unsigned(un[1]),
    .req_addr(ad[1]), .req_wdata(wd[1]), .resp_valid(vld[1]),
    .resp_rdata(rdat[1]), .resp_err(er[1])
  );

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h", nm, d, act, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference model: byte-addressed memory and cycles until response.
  logic [7:0] mb    [2][DEPTH*4];
  int         busy  [2];
  word_t      pdata [2];
  logic       perr  [2];
  logic       live  [2];

  task automatic model_accept(input int d);
    int unsigned a, n, base;
    word_t v;
    a     = ad[d] % (DEPTH * 4);
    n     = (sz[d] == BYTE) ? 1 : (sz[d] == HALF) ? 2 : 4;
    base  = a - (a % n);
    perr[d]  = 1'b0;
    pdata[d] = '0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((a % n) != 0) begin
      perr[d] = 1'b1;
      return;
    end
`endif
    if (we[d]) begin
      for (int i = 0; i < int'(n); i++) mb[d][base+i] = wd[d][8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < int'(n); i++) v[8*i +: 8] = mb[d][base+i];
      if (n < 4 && !un[d] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      pdata[d] = v;
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        busy[d] = 0;
        live[d] = 1'b1;
      end else if (busy[d] == 0) begin
        if (rv[d]) begin
          model_accept(d);
          busy[d] = lat_of(d);
        end
      end else begin
        busy[d]--;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (live[d]) begin
        chk("cyc_ready", d, 32'(rdy[d]), 32'(busy[d] == 0));
        chk("cyc_valid", d, 32'(vld[d]), 32'(busy[d] == 1));
        chk("cyc_rdata", d, rdat[d], (busy[d] == 1) ? pdata[d] : '0);
        chk("cyc_err", d, 32'(er[d]), 32'((busy[d] == 1) && perr[d]));
      end
    end
  end

  task automatic xact(input int d, input logic w, input mem_size_e s,
                      input logic u, input logic [31:0] a,
                      input logic [31:0] dat,
                      output logic [31:0] rd, output logic e);
    int n;
    n = 0;
    while (!rdy[d] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", d, 32'(rdy[d]), 32'd1);
    rv[d] = 1'b1; we[d] = w; sz[d] = s; un[d] = u;
    ad[d] = a; wd[d] = dat;
    @(posedge clk); #1;
    rv[d] = 1'b0;
    n = 1;
    while (!vld[d] && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("resp_wait", d, 32'(vld[d]), 32'd1);
    chk("latency", d, 32'(n), 32'(lat_of(d)));
    rd = rdat[d];
    e  = er[d];
    @(posedge clk); #1;
  endtask

  task automatic ld(input int d, input mem_size_e s, input logic u,
                    input logic [31:0] a, input logic [31:0] exp,
                    input string nm);
    logic [31:0] rd;
    logic e;
    xact(d, 1'b0, s, u, a, 32'd0, rd, e);
    chk(nm, d, rd, exp);
    chk({nm, "_err"}, d, 32'(e), 32'd0);
  endtask

  task automatic st(input int d, input mem_size_e s,
                    input logic [31:0] a, input logic [31:0] dat);
    logic [31:0] rd;
    logic e;
    xact(d, 1'b1, s, 1'b0, a, dat, rd, e);
    chk("st_rdata", d, rd, 32'd0);
    chk("st_err", d, 32'(e), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          acc[$];
    int          lows, seen;

    live = '{1'b0, 1'b0};
    rst  = '{1'b1, 1'b1};
    rv   = '{1'b0, 1'b0};
    we   = '{1'b0, 1'b0};
    sz   = '{WORD, WORD};
    un   = '{1'b0, 1'b0};
    ad   = '{32'd0, 32'd0};
    wd   = '{32'd0, 32'd0};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, 32'(rdy[d]), 32'd1);
      chk("rst_valid", d, 32'(vld[d]), 32'd0);
      chk("rst_rdata", d, rdat[d], 32'd0);
      chk("rst_err", d, 32'(er[d]), 32'd0);
    end
    rst = '{1'b0, 1'b0};
    @(posedge clk); #1;

    st(0, WORD, 32'h10, 32'hDEAD_BEEF);
    ld(0, WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, "lw_10");

    st(0, BYTE, 32'h11, 32'h0000_007F);
    ld(0, BYTE, 1'b0, 32'h11, 32'h0000_007F, "lb_11");
    st(0, BYTE, 32'h12, 32'h0000_0080);
    ld(0, BYTE, 1'b0, 32'h12, 32'hFFFF_FF80, "lb_12");
    ld(0, BYTE, 1'b1, 32'h12, 32'h0000_0080, "lbu_12");
    ld(0, WORD, 1'b0, 32'h10, 32'hDE80_7FEF, "lw_10_bytes");

    st(0, WORD, 32'h20, 32'h1234_5678);
    st(0, HALF, 32'h22, 32'h0000_BEEF);
    ld(0, HALF, 1'b0, 32'h22, 32'hFFFF_BEEF, "lh_22");
    ld(0, HALF, 1'b1, 32'h22, 32'h0000_BEEF, "lhu_22");
    ld(0, WORD, 1'b0, 32'h20, 32'hBEEF_5678, "lw_20");
    ld(0, HALF, 1'b0, 32'h20, 32'h0000_5678, "lh_20");
    ld(0, mem_size_e'(2'b11), 1'b0, 32'h20, 32'hBEEF_5678, "lsz3_20");
    ld(0, WORD, 1'b0, 32'h1000_0050, 32'hDE80_7FEF, "lw_wrap");

    xact(0, 1'b1, WORD, 1'b0, 32'h13, 32'hCAFE_F00D, rd, e);
    chk("sw13_err", 0, 32'(e), 32'(TRAP));
    ld(0, WORD, 1'b0, 32'h10,
       TRAP ? 32'hDE80_7FEF : 32'hCAFE_F00D, "lw_after_sw13");
    xact(0, 1'b0, HALF, 1'b0, 32'h21, 32'd0, rd, e);
    chk("lh21_rdata", 0, rd, TRAP ? 32'd0 : 32'h0000_5678);
    chk("lh21_err", 0, 32'(e), 32'(TRAP));

    st(1, WORD, 32'h10, 32'h0BAD_F00D);
    ld(1, WORD, 1'b0, 32'h10, 32'h0BAD_F00D, "l3_lw_10");
    rv[1] = 1'b1; we[1] = 1'b0; sz[1] = WORD;
    un[1] = 1'b0; ad[1] = 32'h10;
    lows = 0;
    for (int k = 0; k < 13; k++) begin
      if (rdy[1]) acc.push_back(k);
      else        lows++;
      @(posedge clk); #1;
    end
    rv[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("l3_accepts", 1, 32'(acc.size()), 32'd4);
    for (int i = 1; i < acc.size(); i++)
      chk("l3_spacing", 1, 32'(acc[i] - acc[i-1]), 32'd4);
    chk("l3_ready_low", 1, 32'(lows), 32'd9);

    rv[1] = 1'b1; we[1] = 1'b0; ad[1] = 32'h10;
    @(posedge clk); #1;
    rv[1] = 1'b0;
    chk("wait_ready", 1, 32'(rdy[1]), 32'd0);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("rst_wait_ready", 1, 32'(rdy[1]), 32'd1);
    seen = 0;
    repeat (5) begin
      if (vld[1]) seen++;
      @(posedge clk); #1;
    end
    chk("rst_wait_noresp", 1, 32'(seen), 32'd0);
    ld(1, WORD, 1'b0, 32'h10, 32'h0BAD_F00D, "l3_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
